// File: rtl/wifi_tx_pkg.sv
// wifi_tx_pkg
//   Shared definitions for the WiFi TX parallel-to-serial / puncture block:
//   code-rate encodings, per-(rate, phase) keep masks and small helpers.
//   Keep masks are {keep A, keep B}; A is the first encoder output of a pair.
package wifi_tx_pkg;

  typedef enum logic [1:0] {
    RATE_1_2  = 2'b00,
    RATE_2_3  = 2'b01,
    RATE_3_4  = 2'b10,
    RATE_RSVD = 2'b11
  } rate_e;

  localparam logic [1:0] MASK_1_2_PH0 = 2'b11;
  localparam logic [1:0] MASK_2_3_PH0 = 2'b11;
  localparam logic [1:0] MASK_2_3_PH1 = 2'b10;
  localparam logic [1:0] MASK_3_4_PH0 = 2'b11;
  localparam logic [1:0] MASK_3_4_PH1 = 2'b10;
  localparam logic [1:0] MASK_3_4_PH2 = 2'b01;

  // The reserved code behaves exactly like rate 1/2.
  function automatic rate_e norm_rate(input logic [1:0] r);
    case (r)
      2'b01:   return RATE_2_3;
      2'b10:   return RATE_3_4;
      default: return RATE_1_2;
    endcase
  endfunction

  // Highest phase index of the puncturing period (P-1).
  function automatic logic [1:0] period_last(input rate_e r);
    case (r)
      RATE_2_3: return 2'd1;
      RATE_3_4: return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/wifi_tx_punct_mask.sv
// wifi_tx_punct_mask
//   Combinational puncture pattern lookup: (rate_q, ph) -> keep mask, K.
//   Only exists when WIFI_TX_PUNCTURE_EN is defined.
//   Ports:
//     rate_q  in   rate in force for the current puncturing period
//     ph      in   phase within the period (0..P-1)
//     keep    out  {keep A, keep B}
//     k       out  number of kept bits (1 or 2)
`ifdef WIFI_TX_PUNCTURE_EN
module wifi_tx_punct_mask
  import wifi_tx_pkg::*;
(
  input  rate_e       rate_q,
  input  logic [1:0]  ph,
  output logic [1:0]  keep,
  output logic [1:0]  k
);

  always_comb begin
    keep = MASK_1_2_PH0;
    case (rate_q)
      RATE_2_3: keep = (ph == 2'd0) ? MASK_2_3_PH0 : MASK_2_3_PH1;
      RATE_3_4: begin
        case (ph)
          2'd0:    keep = MASK_3_4_PH0;
          2'd1:    keep = MASK_3_4_PH1;
          default: keep = MASK_3_4_PH2;
        endcase
      end
      default:  keep = MASK_1_2_PH0;
    endcase
  end

  assign k = {1'b0, keep[1]} + {1'b0, keep[0]};

endmodule
`endif

// File: rtl/wifi_tx_ptos_punct.sv
// wifi_tx_ptos_punct
//   Parallel-to-serial converter between the convolutional encoder and the
//   interleaver. One DATA_W-bit word per ready/valid handshake, one bit out
//   per clock, no bubbles between back-to-back words.
//   Optional puncturing (rates 1/2, 2/3, 3/4) when WIFI_TX_PUNCTURE_EN is
//   defined; that build requires DATA_W == 2.
//   Ports:
//     clk        in   clock, rising edge
//     reset      in   asynchronous, active-low
//     valid_in   in   input word valid
//     ready_in   out  block can accept a word (no bits pending)
//     data_in    in   coded word; DATA_W=2: A=data_in[1], B=data_in[0]
//     last_in    in   final word of the frame
//     rate       in   00=1/2, 01=2/3, 10=3/4, 11=treated as 1/2
//     valid_out  out  data_out valid
//     data_out   out  serial bit (holds its value when idle)
//     last_out   out  final bit of a last_in word
//     busy       out  bits remain to be emitted
module wifi_tx_ptos_punct
  import wifi_tx_pkg::*;
#(
  parameter int DATA_W    = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              last_in,
  input  logic [1:0]        rate,
  output logic              valid_out,
  output logic              data_out,
  output logic              last_out,
  output logic              busy
);

  localparam int REM_W = $clog2(DATA_W + 1);

  logic [REM_W-1:0]  r_rem;
  logic [DATA_W-1:0] r_sreg;
  logic              r_last_word;
  logic              r_valid_out;
  logic              r_data_out;
  logic              r_last_out;

  logic              w_acc;
  logic [DATA_W-1:0] w_ord;
  logic [DATA_W-1:0] w_comp;
  logic [REM_W-1:0]  w_k;

  assign ready_in  = (r_rem == '0);
  assign busy      = (r_rem != '0);
  assign w_acc     = valid_in && ready_in;
  assign valid_out = r_valid_out;
  assign data_out  = r_data_out;
  assign last_out  = r_last_out;

  // Reorder so the first bit to transmit always sits in the MSB.
  always_comb begin
    w_ord = data_in;
    if (!MSB_FIRST) begin
      for (int i = 0; i < DATA_W; i++) w_ord[i] = data_in[DATA_W-1-i];
    end
  end

`ifdef WIFI_TX_PUNCTURE_EN
  if (DATA_W != 2) begin : g_bad_width
    $error("wifi_tx_ptos_punct: puncturing requires DATA_W == 2");
  end

  logic [1:0] r_ph;
  rate_e      r_rate_q;
  rate_e      w_rate_eff;
  logic [1:0] w_keep;
  logic [1:0] w_keep_ord;
  logic [1:0] w_k2;

  // A phase-0 word opens a new period and already uses the incoming rate.
  assign w_rate_eff = (r_ph == 2'd0) ? norm_rate(rate) : r_rate_q;

  wifi_tx_punct_mask u_mask (
    .rate_q (w_rate_eff),
    .ph     (r_ph),
    .keep   (w_keep),
    .k      (w_k2)
  );

  assign w_keep_ord = MSB_FIRST ? w_keep : {w_keep[0], w_keep[1]};
  // Masks are never empty: if the first bit is dropped, the second moves up.
  assign w_comp     = w_keep_ord[1] ? w_ord : (w_ord << 1);
  assign w_k        = REM_W'(w_k2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ph     <= 2'd0;
      r_rate_q <= RATE_1_2;
    end else if (w_acc) begin
      if (r_ph == 2'd0) r_rate_q <= norm_rate(rate);
      if (last_in || (r_ph == period_last(w_rate_eff))) r_ph <= 2'd0;
      else                                               r_ph <= r_ph + 2'd1;
    end
  end
`else
  logic w_unused_rate;
  assign w_unused_rate = ^rate;
  assign w_comp        = w_ord;
  assign w_k           = REM_W'(DATA_W);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rem       <= '0;
      r_sreg      <= '0;
      r_last_word <= 1'b0;
      r_valid_out <= 1'b0;
      r_data_out  <= 1'b0;
      r_last_out  <= 1'b0;
    end else if (w_acc) begin
      r_data_out  <= w_comp[DATA_W-1];
      r_sreg      <= w_comp << 1;
      r_rem       <= w_k - 1'b1;
      r_valid_out <= 1'b1;
      r_last_word <= last_in;
      r_last_out  <= last_in && (w_k == REM_W'(1));
    end else if (r_rem != '0) begin
      r_data_out  <= r_sreg[DATA_W-1];
      r_sreg      <= r_sreg << 1;
      r_rem       <= r_rem - 1'b1;
      r_valid_out <= 1'b1;
      r_last_out  <= r_last_word && (r_rem == REM_W'(1));
    end else begin
      r_valid_out <= 1'b0;
      r_last_out  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wifi_tx_ptos_punct.sv
module tb_wifi_tx_ptos_punct;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_in;
  logic       ready_in;
  logic [1:0] data_in;
  logic       last_in;
  logic [1:0] rate;
  logic       valid_out, data_out, last_out, busy;

  always #5 clk = ~clk;

  wifi_tx_ptos_punct #(.DATA_W(2), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
    .data_in(data_in), .last_in(last_in), .rate(rate),
    .valid_out(valid_out), .data_out(data_out), .last_out(last_out), .busy(busy)
  );

`ifndef WIFI_TX_PUNCTURE_EN
  logic       v8, rdy8, l8, vo8, do8, lo8, bz8;
  logic [7:0] d8;
  logic [1:0] r8;
  wifi_tx_ptos_punct #(.DATA_W(8), .MSB_FIRST(1'b0)) dut8 (
    .clk(clk), .reset(reset), .valid_in(v8), .ready_in(rdy8),
    .data_in(d8), .last_in(l8), .rate(r8),
    .valid_out(vo8), .data_out(do8), .last_out(lo8), .busy(bz8)
  );
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queue of pending {bit, last} plus puncture period state.
  logic [1:0] q[$];
  int         m_ph;
  int         m_rate_q;
  logic       m_hold;
  logic [4:0] exp_v, obs_v;   // {valid, data, last, ready, busy}

  function automatic int norm(input logic [1:0] r);
    return (r == 2'b11) ? 0 : int'(r);
  endfunction

  task automatic model_clear();
    q.delete();
    m_ph = 0; m_rate_q = 0; m_hold = 1'b0;
  endtask

  // Phase pattern: ph0 keeps A and B, ph1 keeps A, ph2 keeps B; the rate only
  // sets the period length (1, 2 or 3 words).
  task automatic model_accept(input logic [1:0] d, input logic l, input logic [1:0] r);
    int eff, p;
    bit ka, kb;
    eff = (m_ph == 0) ? norm(r) : m_rate_q;
`ifdef WIFI_TX_PUNCTURE_EN
    ka = (m_ph != 2);
    kb = (m_ph == 0) || (m_ph == 2);
    p  = (eff == 1) ? 2 : (eff == 2) ? 3 : 1;
`else
    ka = 1; kb = 1; p = 1;
`endif
    if (ka) q.push_back({d[1], l && !kb});
    if (kb) q.push_back({d[0], l});
    if (m_ph == 0) m_rate_q = eff;
    m_ph = l ? 0 : (m_ph + 1) % p;
  endtask

  task automatic tick(input logic v, input logic [1:0] d, input logic l,
                      input logic [1:0] r, output logic acc);
    logic [1:0] e;
    valid_in = v; data_in = d; last_in = l; rate = r;
    acc = v && ready_in;
    if (acc) model_accept(d, l, r);
    @(posedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      e = q.pop_front();
      m_hold = e[1];
      exp_v[4:2] = {1'b1, e[1], e[0]};
    end else begin
      exp_v[4:2] = {1'b0, m_hold, 1'b0};
    end
    exp_v[1] = (q.size() == 0);
    exp_v[0] = (q.size() != 0);
    obs_v = {valid_out, data_out, last_out, ready_in, busy};
  endtask

  task automatic apply_reset();
    reset = 1'b0; valid_in = 1'b0; last_in = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    logic acc;
    reset = 1'b0; valid_in = 1'b1; data_in = 2'b10; last_in = 1'b0; rate = 2'b00;
    model_clear();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({valid_out, data_out, last_out, ready_in, busy} !== 5'b00010) begin
        n_bad++;
        $display("FAIL reset_hold got %b want 00010", {valid_out, data_out, last_out, ready_in, busy});
      end
    end
    reset = 1'b1;
    tick(1'b1, 2'b10, 1'b0, 2'b00, acc);
    n_cmp++;
    if (obs_v !== exp_v || acc !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_first_accept got %b acc %b want %b acc 1", obs_v, acc, exp_v);
    end
    for (int c = 0; c < 2; c++) begin
      tick(1'b0, 2'b00, 1'b0, 2'b00, acc);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL reset_drain got %b want %b", obs_v, exp_v);
      end
    end
  endtask

  task automatic test_rate12_b2b();
    logic [1:0] w[3] = '{2'b10, 2'b01, 2'b11};
    logic acc;
    logic [15:0] s = '0;
    int i = 0, nb = 0;
    apply_reset();
    for (int c = 0; c < 20 && (i < 3 || q.size() != 0); c++) begin
      tick(i < 3, (i < 3) ? w[i] : 2'b00, 1'b0, 2'b00, acc);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL rate12_cycle %0d got %b want %b", c, obs_v, exp_v);
      end
      if (obs_v[4]) begin s = {s[14:0], obs_v[3]}; nb++; end
      if (acc) i++;
    end
    n_cmp++;
    if (s !== 16'b100111 || nb !== 6) begin
      n_bad++;
      $display("FAIL rate12_stream got %b (%0d bits) want 100111 (6 bits)", s, nb);
    end
  endtask

  task automatic test_rate34_last();
    logic [1:0] w[3] = '{2'b11, 2'b01, 2'b10};
    logic acc;
    logic [15:0] s = '0;
    int i = 0, nb = 0, lpos = 0;
`ifdef WIFI_TX_PUNCTURE_EN
    logic [15:0] exp_s = 16'b1100;
    int exp_n = 4;
`else
    logic [15:0] exp_s = 16'b110110;
    int exp_n = 6;
`endif
    apply_reset();
    for (int c = 0; c < 20 && (i < 3 || q.size() != 0); c++) begin
      tick(i < 3, (i < 3) ? w[i] : 2'b00, i == 2, 2'b10, acc);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL rate34_cycle %0d got %b want %b", c, obs_v, exp_v);
      end
      if (obs_v[4]) begin s = {s[14:0], obs_v[3]}; nb++; if (obs_v[2]) lpos = nb; end
      if (acc) i++;
    end
    n_cmp++;
    if (s !== exp_s || nb !== exp_n || lpos !== exp_n) begin
      n_bad++;
      $display("FAIL rate34_stream got %b n=%0d last@%0d want %b n=%0d last@%0d",
               s, nb, lpos, exp_s, exp_n, exp_n);
    end
    // Phase must be back at 0: a 2/3 word now keeps both bits.
    for (int c = 0; c < 3; c++) begin
      tick(c == 0, 2'b11, 1'b0, 2'b01, acc);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL rate34_phase0 got %b want %b", obs_v, exp_v);
      end
    end
  endtask

  task automatic test_rate_change();
    logic [1:0] w[5]  = '{2'b11, 2'b10, 2'b01, 2'b11, 2'b01};
    logic [1:0] rt[5] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10};
    logic acc;
    logic [15:0] s = '0;
    int i = 0, nb = 0;
`ifdef WIFI_TX_PUNCTURE_EN
    logic [15:0] exp_s = 16'b1110111;
    int exp_n = 7;
`else
    logic [15:0] exp_s = 16'b1110011101;
    int exp_n = 10;
`endif
    apply_reset();
    for (int c = 0; c < 30 && (i < 5 || q.size() != 0); c++) begin
      tick(i < 5, (i < 5) ? w[i] : 2'b00, i == 4, (i < 5) ? rt[i] : 2'b00, acc);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL rate_change_cycle %0d got %b want %b", c, obs_v, exp_v);
      end
      if (obs_v[4]) begin s = {s[14:0], obs_v[3]}; nb++; end
      if (acc) i++;
    end
    n_cmp++;
    if (s !== exp_s || nb !== exp_n) begin
      n_bad++;
      $display("FAIL rate_change_stream got %b n=%0d want %b n=%0d", s, nb, exp_s, exp_n);
    end
  endtask

  task automatic test_reset_midword();
    logic acc;
    apply_reset();
    tick(1'b1, 2'b11, 1'b0, 2'b01, acc);
    n_cmp++;
    if (obs_v !== exp_v) begin
      n_bad++;
      $display("FAIL midword_pre got %b want %b", obs_v, exp_v);
    end
    #2 reset = 1'b0;
    #1;
    model_clear();
    n_cmp++;
    if ({valid_out, data_out, last_out, ready_in, busy} !== 5'b00010) begin
      n_bad++;
      $display("FAIL midword_async got %b want 00010", {valid_out, data_out, last_out, ready_in, busy});
    end
    @(negedge clk);
    valid_in = 1'b0;
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick(c == 1, 2'b10, 1'b0, 2'b01, acc);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL midword_post cycle %0d got %b want %b", c, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic acc;
    int i = 0, nb = 0, first = -1, lastc = -1;
`ifdef WIFI_TX_PUNCTURE_EN
    int exp_n = 16;
`else
    int exp_n = 24;
`endif
    apply_reset();
    for (int c = 0; c < 60 && (i < 12 || q.size() != 0); c++) begin
      tick(i < 12, 2'($urandom), 1'b0, 2'b10, acc);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL b2b_cycle %0d got %b want %b", c, obs_v, exp_v);
      end
      if (obs_v[4]) begin nb++; if (first < 0) first = c; lastc = c; end
      if (acc) i++;
    end
    n_cmp++;
    if (nb !== exp_n || (lastc - first + 1) !== exp_n) begin
      n_bad++;
      $display("FAIL b2b_throughput got %0d bits over %0d cycles want %0d contiguous",
               nb, lastc - first + 1, exp_n);
    end
  endtask

  task automatic test_random();
    logic acc;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      tick($urandom_range(0, 9) < 7, 2'($urandom), $urandom_range(0, 7) == 0,
           2'($urandom_range(0, 3)), acc);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL random_cycle %0d got %b want %b", c, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_wide();
`ifndef WIFI_TX_PUNCTURE_EN
    logic [7:0] word;
    logic [7:0] s;
    logic       lw;
    for (int k = 0; k < 4; k++) begin
      word = (k == 0) ? 8'hA5 : 8'($urandom);
      lw   = (k == 3);
      s    = '0;
      v8 = 1'b1; d8 = word; l8 = lw; r8 = 2'($urandom);
      n_cmp++;
      if (rdy8 !== 1'b1) begin
        n_bad++;
        $display("FAIL wide_ready word %0d got %b want 1", k, rdy8);
      end
      @(posedge clk); @(negedge clk);
      v8 = 1'b0;
      for (int b = 0; b < 8; b++) begin
        n_cmp++;
        if ({vo8, do8, lo8} !== {1'b1, word[b], lw && (b == 7)}) begin
          n_bad++;
          $display("FAIL wide_bit word %0d bit %0d got %b want %b",
                   k, b, {vo8, do8, lo8}, {1'b1, word[b], lw && (b == 7)});
        end
        s = {s[6:0], do8};
        r8 = 2'($urandom);
        if (b != 7) @(negedge clk);
      end
      if (k == 0) begin
        n_cmp++;
        if (s !== 8'hA5) begin
          n_bad++;
          $display("FAIL wide_a5_stream got %b want 10100101", s);
        end
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({vo8, rdy8, bz8} !== 3'b010) begin
      n_bad++;
      $display("FAIL wide_idle got %b want 010", {vo8, rdy8, bz8});
    end
`endif
  endtask

  initial begin
    valid_in = 1'b0; data_in = 2'b00; last_in = 1'b0; rate = 2'b00;
`ifndef WIFI_TX_PUNCTURE_EN
    v8 = 1'b0; d8 = '0; l8 = 1'b0; r8 = 2'b00;
`endif
    test_reset();
    test_rate12_b2b();
    test_rate34_last();
    test_rate_change();
    test_reset_midword();
    test_back_to_back();
    test_random();
    apply_reset();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wifi_tx_ptos_punct.md
# wifi_tx_ptos_punct

Parametrised parallel-to-serial converter for the WiFi TX chain, between the convolutional encoder and the interleaver. Accepts one DATA_W-bit coded word per handshake and emits its bits serially, one per clock, with zero-bubble back-to-back throughput and ready/valid backpressure toward the encoder. Optionally applies 802.11a puncturing (rates 1/2, 2/3, 3/4) to the rate-1/2 encoder output. Punctured bits consume no output cycle.

## Interface
- DATA_W, 2: bits per input word; must be ≥ 2.
- MSB_FIRST, 1: 1 = data_in[DATA_W-1] is sent first; 0 = data_in[0] is sent first.

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- valid_in  in  1  input word valid
- ready_in  out  1  block can accept a word this cycle
- data_in  in  DATA_W  coded word; for DATA_W=2, A=data_in[1], B=data_in[0]
- last_in  in  1  word is the final word of the frame; qualified by valid_in&&ready_in
- rate  in  2  00 = 1/2, 01 = 2/3, 10 = 3/4, 11 = reserved, treated as 1/2
- valid_out  out  1  data_out valid
- data_out  out  1  serial bit
- last_out  out  1  high with the final bit of a last_in word
- busy  out  1  high while bits remain to be emitted (rem≠0)

## Operation
- Accept occurs when valid_in && ready_in. ready_in = (rem==0), driven combinationally from the register.
- On accept:
  - Compute the keep mask for the word and set kept-bit count K.
  - Drive the first kept bit on data_out, set valid_out=1, set rem=K-1.
  - Store the remaining kept bits, compacted, in the shift register.
- Each later cycle with rem>0: drive the next kept bit, valid_out=1, rem-=1.
- If rem==0 and there is no accept: valid_out=0. data_out holds its last value.
- last_out=1 only on the cycle that drives the final kept bit of a word accepted with last_in; otherwise 0.
- Puncture phase counter ph is 0..P-1, where P=1 for rate 1/2, 2 for 2/3, 3 for 3/4.
  - ph advances on every accept and wraps to 0 after P-1.
  - ph is forced to 0 after a last_in accept.
- rate is sampled on accepts with ph==0 into rate_q. rate_q is used for the whole period. Changes to rate while ph≠0 are ignored until the period completes.
- Patterns (keep A,B per pair):
  - 1/2: {AB}
  - 2/3: ph0 {AB}, ph1 {A}
  - 3/4: ph0 {AB}, ph1 {A}, ph2 {B}
  - Every pair yields 1 or 2 bits.
- Reset (asynchronous, any time): rem=0, ph=0, rate_q=00, valid_out=0, data_out=0, last_out=0. Pending bits are discarded. ready_in=1 immediately after reset deasserts.
- Reset values of all outputs: ready_in=1, valid_out=0, data_out=0, last_out=0, busy=0.

## Timing
- Latency: the first bit is registered at the edge that accepts the word and is visible one cycle after accept.
- A K-bit word occupies K output cycles.
- ready_in rises in the cycle after the last bit is driven, so the next accept lands on the following edge. valid_out then stays high continuously while valid_in stays high.
- Throughput: 1 bit/clk.
  - Rate 1/2, DATA_W=2: one word every 2 cycles.
  - Rate 3/4: 4 bits per 3 words.
- rem width is $clog2(DATA_W+1). ph width is 2 bits.
- Simultaneous accept and final-bit drive cannot occur, because ready_in requires rem==0.

## Configuration
- WIFI_TX_PUNCTURE_EN
  - Defined:
    - The rate port, ph and rate_q are active as described above.
    - DATA_W must equal 2. Any other value raises an elaboration-time $error.
  - Undefined:
    - rate is ignored. K = DATA_W for every word, and all bits are sent in MSB_FIRST order.
    - ph and rate_q are not instantiated.
    - Any DATA_W ≥ 2 is allowed.

## Structure
- Shared package wifi_tx_pkg holds:
  - rate encodings: RATE_1_2, RATE_2_3, RATE_3_4.
  - puncture keep-mask constants per (rate, ph).
- One sub-module: wifi_tx_punct_mask. It is combinational: (rate_q, ph) -> 2-bit keep mask and K. It is instantiated only under WIFI_TX_PUNCTURE_EN.
- The shift register, rem counter and handshake live in the top module.

## Test plan
- Reset with valid_in=1 held low-to-high: ready_in=1 and valid_out=0 during reset. First accept one cycle after release yields data_out on the next cycle.
- Rate 1/2, DATA_W=2, words 10,01,11 back-to-back: serial 1,0,0,1,1,1 with valid_out high for 6 contiguous cycles and ready_in pulsing every 2nd cycle.
- Rate 3/4, words 11,01,10 (ph0..2), last_in on the third: output A0 B0 A1 B2 = 1,1,0,0. last_out is high on the 4th bit. ph returns to 0.
- Rate 2/3 with rate changed to 3/4 while ph=1: the second word still emits A only. The new rate takes effect from the next ph=0 word.
- Reset asserted mid-word, with rem=1: valid_out drops to 0 immediately and the pending bit is never emitted. After release, ph=0.
- Macro undefined, DATA_W=8, MSB_FIRST=0, word 0xA5: bits 1,0,1,0,0,1,0,1 over 8 cycles with rate toggled arbitrarily, which has no effect.
